// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: round-robin sharing of memory_bus between the 6502 (cpu_*) and a block-copy DMA (dma_* control), driving mem_*; clk, async active-low reset
module dma_bus_arbiter #(
  parameter int READ_LATENCY = 1,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          cpu_address,
  input  logic [7:0]           cpu_data_out,
  output logic [7:0]           cpu_data_in,
  input  logic                 cpu_bus_enable,
  input  logic                 cpu_write_enable,
  output logic                 cpu_ready,
  input  logic                 dma_start,
  input  logic [15:0]          dma_src,
  input  logic [15:0]          dma_dst,
  input  logic [LEN_WIDTH-1:0] dma_length,
  output logic                 dma_busy,
  output logic                 dma_done,
  output logic [15:0]          mem_address,
  output logic [7:0]           mem_data_in,
  input  logic [7:0]           mem_data_out,
  output logic                 mem_bus_enable,
  output logic                 mem_write_enable
);
  localparam logic [2:0] IDLE = 3'd0, ARB = 3'd1, RD = 3'd2, WR = 3'd3, FIN = 3'd4;
  localparam logic [1:0] RD_LAST = 2'(READ_LATENCY);
  logic [2:0] state_q, state_d;
  logic [15:0] src_q, src_d, dst_q, dst_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [7:0] data_q, data_d;
  logic [1:0] lat_q, lat_d;
  logic last_dma_q, last_dma_d;
  logic cpu_grant;
  assign cpu_grant = state_q == IDLE || state_q == FIN || (state_q == ARB && cpu_bus_enable && last_dma_q);
  always_comb begin
    state_d = state_q;
    src_d = src_q;
    dst_d = dst_q;
    rem_d = rem_q;
    data_d = data_q;
    lat_d = '0;
    last_dma_d = last_dma_q;
    case (state_q)
      IDLE: if (dma_start) begin
        src_d = dma_src;
        dst_d = dma_dst;
        rem_d = dma_length;
        state_d = dma_length == '0 ? FIN : ARB;
      end
      ARB: if (cpu_grant) last_dma_d = 1'b0;
           else state_d = RD;
      RD: if (lat_q == RD_LAST) begin
        data_d = mem_data_out;
        state_d = WR;
      end else lat_d = lat_q + 2'd1;
      WR: begin
        src_d = src_q + 16'd1;
        dst_d = dst_q + 16'd1;
        rem_d = rem_q - LEN_WIDTH'(1);
        last_dma_d = 1'b1;
        state_d = rem_q == LEN_WIDTH'(1) ? FIN : ARB;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q <= '0;
      dst_q <= '0;
      rem_q <= '0;
      data_q <= '0;
      lat_q <= '0;
      last_dma_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q <= src_d;
      dst_q <= dst_d;
      rem_q <= rem_d;
      data_q <= data_d;
      lat_q <= lat_d;
      last_dma_q <= last_dma_d;
    end
  end
  assign dma_busy = state_q == ARB || state_q == RD || state_q == WR;
  assign dma_done = state_q == FIN;
  assign cpu_ready = cpu_grant || (state_q == ARB && !cpu_bus_enable);
  assign cpu_data_in = mem_data_out;
  assign mem_address = cpu_grant ? cpu_address : (state_q == WR ? dst_q : src_q);
  assign mem_data_in = cpu_grant ? cpu_data_out : data_q;
  assign mem_bus_enable = cpu_grant ? cpu_bus_enable : (state_q == RD || state_q == WR);
  assign mem_write_enable = cpu_grant ? cpu_write_enable : state_q == WR;
endmodule
